// File: rtl/lif_pkg.sv
// Shared definitions for the LIF integrate-and-fire stage: FSM state type,
// default widths and a saturating-max helper.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAK,
    ST_UPDATE
  } state_t;

  localparam int unsigned DEFAULT_VMEM_W = 16;
  localparam int unsigned DEFAULT_SHIFT  = 4;

  function automatic logic [31:0] sat_max(input int unsigned width);
    if (width >= 32) return '1;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/lif_leak_calc.sv
// Registered guaranteed-decay leak: (v >> SHIFT) + 1 for nonzero v, else 0.
module lif_leak_calc
  import lif_pkg::*;
#(
  parameter int unsigned VMEM_W = DEFAULT_VMEM_W,
  parameter int unsigned SHIFT  = DEFAULT_SHIFT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [VMEM_W-1:0] v,
  output logic [VMEM_W-1:0] leak
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      leak <= '0;
    end else if (en) begin
      leak <= (v != '0) ? (v >> SHIFT) + VMEM_W'(1) : '0;
    end
  end

endmodule

// File: rtl/lif_integrate_fire.sv
// Time-multiplexed leak-integrate-fire stage for a bank of neurons.
// Optional spike counter enabled by defining LIF_SPIKE_COUNT_EN.
module lif_integrate_fire
  import lif_pkg::*;
#(
  parameter int unsigned VMEM_W        = DEFAULT_VMEM_W,
  parameter int unsigned NUM_NEURONS   = 8,
  parameter int unsigned IDX_W         = 3,
  parameter int unsigned SHIFT         = DEFAULT_SHIFT,
  parameter int unsigned THRESH        = 1000,
  parameter int unsigned REFRAC_EVENTS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_all,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [VMEM_W-1:0] in_current,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_spike,
  output logic [VMEM_W-1:0] out_vmem,
  output logic [15:0]       spike_count
);

  localparam int unsigned AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned RW = (REFRAC_EVENTS > 0) ? $clog2(REFRAC_EVENTS + 1) : 1;
  localparam logic [31:0]       SAT32    = sat_max(VMEM_W);
  localparam logic [VMEM_W-1:0] VMAX     = SAT32[VMEM_W-1:0];
  localparam logic [VMEM_W-1:0] THR      = VMEM_W'(THRESH);
  localparam logic [IDX_W:0]    NN_V     = (IDX_W + 1)'(NUM_NEURONS);
  localparam logic [RW-1:0]     REFRAC_V = RW'(REFRAC_EVENTS);

  state_t state, state_nxt;

  logic [VMEM_W-1:0] vmem   [NUM_NEURONS];
  logic [RW-1:0]     refrac [NUM_NEURONS];

  logic [IDX_W-1:0]  idx_r;
  logic [VMEM_W-1:0] cur_r, v_r, leak_r;
  logic [VMEM_W:0]   sum_full;
  logic [VMEM_W-1:0] sum_sat;
  logic              fire, in_range;
  logic [AW-1:0]     slot_in, slot_r;

  assign slot_in  = in_idx[AW-1:0];
  assign slot_r   = idx_r[AW-1:0];
  assign in_range = {1'b0, in_idx} < NN_V;

  // Leak never exceeds v_r, so the subtraction cannot wrap; only the add can overflow.
  assign sum_full = {1'b0, v_r - leak_r} + {1'b0, cur_r};
  assign sum_sat  = sum_full[VMEM_W] ? VMAX : sum_full[VMEM_W-1:0];
  assign fire     = sum_sat >= THR;

  lif_leak_calc #(
    .VMEM_W(VMEM_W),
    .SHIFT (SHIFT)
  ) u_leak (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == ST_LEAK),
    .v    (v_r),
    .leak (leak_r)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == ST_IDLE);
    case (state)
      ST_IDLE:   if (in_valid && in_range) state_nxt = ST_LEAK;
      ST_LEAK:   state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (clear_all) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        vmem[i]   <= '0;
        refrac[i] <= '0;
      end
      idx_r     <= '0;
      cur_r     <= '0;
      v_r       <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_spike <= 1'b0;
      out_vmem  <= '0;
    end else if (clear_all) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        vmem[i]   <= '0;
        refrac[i] <= '0;
      end
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid && in_range) begin
            idx_r <= in_idx;
            cur_r <= in_current;
            v_r   <= vmem[slot_in];
          end
        end
        ST_UPDATE: begin
          out_valid <= 1'b1;
          out_idx   <= idx_r;
          if (refrac[slot_r] != '0) begin
            vmem[slot_r]   <= '0;
            refrac[slot_r] <= refrac[slot_r] - RW'(1);
            out_spike      <= 1'b0;
            out_vmem       <= '0;
          end else if (fire) begin
            vmem[slot_r]   <= '0;
            refrac[slot_r] <= REFRAC_V;
            out_spike      <= 1'b1;
            out_vmem       <= '0;
          end else begin
            vmem[slot_r]   <= sum_sat;
            out_spike      <= 1'b0;
            out_vmem       <= sum_sat;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_count <= '0;
    end else if (out_valid && out_spike && (spike_count != '1)) begin
      spike_count <= spike_count + 16'd1;
    end
  end
`else
  assign spike_count = '0;
`endif

endmodule

// File: tb/tb_lif_integrate_fire.sv
// Scoreboard bench for lif_integrate_fire; one instance with a widened index
// port, one with THRESH = 65535 for the saturation case.
module tb_lif_integrate_fire;

  typedef struct {
    logic [3:0]  idx;
    logic        spike;
    logic [15:0] vmem;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_all = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_idx = '0;
  logic [15:0] in_current = '0;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic        out_spike;
  logic [15:0] out_vmem;
  logic [15:0] spike_count;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [2:0]  s_in_idx = '0;
  logic [15:0] s_in_current = '0;
  logic        s_out_valid;
  logic [2:0]  s_out_idx;
  logic        s_out_spike;
  logic [15:0] s_out_vmem;
  logic [15:0] s_spike_count;

  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_spikes = 0;
  int   sel = 0;
  exp_t sb[$];
  int   m_vmem[4];
  int   m_refrac[4];

  always #5 clk = ~clk;

  lif_integrate_fire #(.IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear_all(clear_all),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_current(in_current),
    .out_valid(out_valid), .out_idx(out_idx), .out_spike(out_spike), .out_vmem(out_vmem),
    .spike_count(spike_count)
  );

  lif_integrate_fire #(.THRESH(65535)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear_all(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_idx(s_in_idx), .in_current(s_in_current),
    .out_valid(s_out_valid), .out_idx(s_out_idx), .out_spike(s_out_spike), .out_vmem(s_out_vmem),
    .spike_count(s_spike_count)
  );

  logic        m_valid, m_ready, m_spike;
  logic [3:0]  m_idx;
  logic [15:0] m_vm;
  assign m_valid = sel ? s_out_valid : out_valid;
  assign m_ready = sel ? s_in_ready  : in_ready;
  assign m_spike = sel ? s_out_spike : out_spike;
  assign m_idx   = sel ? {1'b0, s_out_idx} : out_idx;
  assign m_vm    = sel ? s_out_vmem  : out_vmem;

  function automatic void model_step(input int idx, input int cur, output bit sp, output int vm);
    int v, lk, s;
    v  = m_vmem[idx];
    lk = (v != 0) ? (v >> 4) + 1 : 0;
    if (m_refrac[idx] != 0) begin
      m_refrac[idx] = m_refrac[idx] - 1;
      m_vmem[idx] = 0; sp = 0; vm = 0;
    end else begin
      s = v - lk + cur;
      if (s > 65535) s = 65535;
      if (s >= 1000) begin
        sp = 1; vm = 0; m_vmem[idx] = 0; m_refrac[idx] = 2;
      end else begin
        sp = 0; vm = s; m_vmem[idx] = s;
      end
    end
  endfunction

  // Entered and left just after a negedge; drives one event and checks its result.
  task automatic send(input int idx, input int cur, input bit exp_valid, input bit sp, input int vm);
    exp_t e, got;
    int   lat;
    n_cmp++;
    if (m_ready !== 1'b1) begin n_err++; $display("FAIL ready_before_event: got %b want 1", m_ready); end
    if (exp_valid) begin
      e.idx = 4'(idx); e.spike = sp; e.vmem = 16'(vm);
      sb.push_back(e);
    end
    if (sel != 0) begin
      s_in_valid = 1'b1; s_in_idx = 3'(idx); s_in_current = 16'(cur);
    end else begin
      in_valid = 1'b1; in_idx = 4'(idx); in_current = 16'(cur);
    end
    @(negedge clk);
    in_valid = 1'b0; s_in_valid = 1'b0;
    lat = 0;
    if (exp_valid) begin
      for (int k = 1; k <= 6 && lat == 0; k++) begin
        @(negedge clk);
        if (m_valid === 1'b1) lat = k;
      end
      n_cmp++;
      if (lat != 2) begin n_err++; $display("FAIL latency idx%0d: got %0d want 2", idx, lat); end
      if (lat != 0) begin
        got = sb.pop_front();
        n_cmp += 4;
        if (m_idx !== got.idx) begin n_err++; $display("FAIL out_idx: got %0d want %0d", m_idx, got.idx); end
        if (m_spike !== got.spike) begin n_err++; $display("FAIL out_spike idx%0d: got %b want %b", idx, m_spike, got.spike); end
        if (m_vm !== got.vmem) begin n_err++; $display("FAIL out_vmem idx%0d: got %0d want %0d", idx, m_vm, got.vmem); end
        if (m_ready !== 1'b1) begin n_err++; $display("FAIL ready_with_result: got %b want 1", m_ready); end
      end else begin
        void'(sb.pop_front());
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL dropped_event_strobe: got %b want 0", m_valid); end
        @(negedge clk);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    n_cmp += 6;
    if (out_valid !== 1'b0)  begin n_err++; $display("FAIL %s out_valid: got %b want 0", tag, out_valid); end
    if (out_idx !== 4'd0)    begin n_err++; $display("FAIL %s out_idx: got %0d want 0", tag, out_idx); end
    if (out_spike !== 1'b0)  begin n_err++; $display("FAIL %s out_spike: got %b want 0", tag, out_spike); end
    if (out_vmem !== 16'd0)  begin n_err++; $display("FAIL %s out_vmem: got %0d want 0", tag, out_vmem); end
    if (spike_count !== 16'd0) begin n_err++; $display("FAIL %s spike_count: got %0d want 0", tag, spike_count); end
    if (in_ready !== 1'b1)   begin n_err++; $display("FAIL %s in_ready: got %b want 1", tag, in_ready); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    exp_spikes = 0;
  endtask

  task automatic test_integrate();
    send(0, 100, 1, 0, 100);
    send(0, 0, 1, 0, 93);
  endtask

  task automatic test_refractory();
    send(1, 1000, 1, 1, 0);
    exp_spikes++;
    send(1, 500, 1, 0, 0);
    send(1, 500, 1, 0, 0);
    send(1, 500, 1, 0, 500);
  endtask

  task automatic test_saturation();
    int want;
    sel = 1;
    send(2, 60000, 1, 0, 60000);
    send(2, 10000, 1, 1, 0);
    sel = 0;
    @(negedge clk);
`ifdef LIF_SPIKE_COUNT_EN
    want = 1;
`else
    want = 0;
`endif
    n_cmp++;
    if (s_spike_count !== 16'(want)) begin n_err++; $display("FAIL sat_spike_count: got %0d want %0d", s_spike_count, want); end
  endtask

  task automatic test_clear();
    in_valid = 1'b1; in_idx = 4'd0; in_current = 16'd50;
    @(negedge clk);
    in_valid = 1'b0;
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    n_cmp += 2;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL clear_ready: got %b want 1", in_ready); end
    if (out_vmem !== 16'd500) begin n_err++; $display("FAIL clear_holds_out_vmem: got %0d want 500", out_vmem); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL clear_no_strobe: got %b want 0", out_valid); end
      @(negedge clk);
    end
    send(0, 0, 1, 0, 0);
  endtask

  task automatic test_bad_index();
    send(8, 123, 0, 0, 0);
    send(3, 5, 1, 0, 5);
  endtask

  task automatic test_back_to_back();
    bit sp;
    int vm, idx, cur;
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    for (int i = 0; i < 4; i++) begin m_vmem[i] = 0; m_refrac[i] = 0; end
    for (int n = 0; n < 24; n++) begin
      idx = int'($urandom_range(0, 3));
      cur = int'($urandom_range(0, 700));
      model_step(idx, cur, sp, vm);
      if (sp) exp_spikes++;
      send(idx, cur, 1, sp, vm);
    end
  endtask

  task automatic test_spike_count();
    int want;
    @(negedge clk);
`ifdef LIF_SPIKE_COUNT_EN
    want = exp_spikes;
`else
    want = 0;
`endif
    n_cmp++;
    if (spike_count !== 16'(want)) begin n_err++; $display("FAIL spike_count: got %0d want %0d", spike_count, want); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_idx = 4'd0; in_current = 16'd999;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    rst_n = 1'b1;
    exp_spikes = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_no_strobe: got %b want 0", out_valid); end
    end
    send(1, 0, 1, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_integrate();
    test_refractory();
    test_saturation();
    test_clear();
    test_bad_index();
    test_back_to_back();
    test_spike_count();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
